// File: rtl/imem_port_arbiter.sv
// Shares one instruction-memory port between fetch (read-only) and loader (read/write).
// One transaction in flight, round-robin on contention, flush-drop of stale fetch data, timeout abort.
module imem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              f_req,
   input  logic [ADDR_W-1:0] f_addr,
   input  logic              f_flush,
   output logic              f_gnt,
   output logic              f_rvalid,
   output logic [DATA_W-1:0] f_rdata,
   input  logic              l_req,
   input  logic              l_we,
   input  logic [ADDR_W-1:0] l_addr,
   input  logic [DATA_W-1:0] l_wdata,
   output logic              l_gnt,
   output logic              l_rvalid,
   output logic [DATA_W-1:0] l_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              timeout
);
   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic { IDLE, WAIT } state_t;
   typedef enum logic { FETCH, LOADER } who_t;

   state_t            state, state_n;
   who_t              last, last_n, owner, owner_n;
   logic              drop, drop_n, wr, wr_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic              f_gnt_n, l_gnt_n, mem_req_n, mem_we_n;
   logic              f_rvalid_n, l_rvalid_n, timeout_n;
   logic [ADDR_W-1:0] mem_addr_n;
   logic [DATA_W-1:0] mem_wdata_n, f_rdata_n, l_rdata_n;
   logic              pick_l;

   // Loader wins if it is the only requester, or on contention when fetch went last.
   assign pick_l = l_req && (!f_req || last == FETCH);

   always_comb begin
      state_n     = state;
      last_n      = last;
      owner_n     = owner;
      drop_n      = drop;
      wr_n        = wr;
      cnt_n       = cnt;
      f_gnt_n     = 1'b0;
      l_gnt_n     = 1'b0;
      mem_req_n   = 1'b0;
      mem_we_n    = 1'b0;
      mem_addr_n  = mem_addr;
      mem_wdata_n = mem_wdata;
      f_rvalid_n  = 1'b0;
      f_rdata_n   = f_rdata;
      l_rvalid_n  = 1'b0;
      l_rdata_n   = l_rdata;
      timeout_n   = 1'b0;
      case (state)
         IDLE: begin
            if (f_req || l_req) begin
               state_n   = WAIT;
               cnt_n     = '0;
               drop_n    = 1'b0;
               mem_req_n = 1'b1;
               if (pick_l) begin
                  owner_n     = LOADER;
                  last_n      = LOADER;
                  l_gnt_n     = 1'b1;
                  mem_we_n    = l_we;
                  wr_n        = l_we;
                  mem_addr_n  = l_addr;
                  mem_wdata_n = l_wdata;
               end else begin
                  owner_n     = FETCH;
                  last_n      = FETCH;
                  f_gnt_n     = 1'b1;
                  wr_n        = 1'b0;
                  mem_addr_n  = f_addr;
                  mem_wdata_n = '0;
               end
            end
         end
         WAIT: begin
            if (mem_rvalid) begin
               state_n = IDLE;
               if (owner == LOADER) begin
                  l_rvalid_n = 1'b1;
                  l_rdata_n  = wr ? '0 : mem_rdata;
               end else if (!drop && !f_flush) begin
                  f_rvalid_n = 1'b1;
                  f_rdata_n  = mem_rdata;
               end
            end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
               state_n   = IDLE;
               timeout_n = 1'b1;
            end else begin
               cnt_n = cnt + CNT_W'(1);
               if (owner == FETCH && f_flush) drop_n = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         last      <= LOADER;
         owner     <= FETCH;
         drop      <= 1'b0;
         wr        <= 1'b0;
         cnt       <= '0;
         f_gnt     <= 1'b0;
         l_gnt     <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         f_rvalid  <= 1'b0;
         f_rdata   <= '0;
         l_rvalid  <= 1'b0;
         l_rdata   <= '0;
         timeout   <= 1'b0;
      end else begin
         state     <= state_n;
         last      <= last_n;
         owner     <= owner_n;
         drop      <= drop_n;
         wr        <= wr_n;
         cnt       <= cnt_n;
         f_gnt     <= f_gnt_n;
         l_gnt     <= l_gnt_n;
         mem_req   <= mem_req_n;
         mem_we    <= mem_we_n;
         mem_addr  <= mem_addr_n;
         mem_wdata <= mem_wdata_n;
         f_rvalid  <= f_rvalid_n;
         f_rdata   <= f_rdata_n;
         l_rvalid  <= l_rvalid_n;
         l_rdata   <= l_rdata_n;
         timeout   <= timeout_n;
      end
   end
endmodule

// File: tb/tb_imem_port_arbiter.sv
// Scoreboard bench for imem_port_arbiter: behavioural memory with programmable latency,
// expected read data queued per requester and popped when the matching rvalid appears.
module tb_imem_port_arbiter;
   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        f_req, f_flush, l_req, l_we;
   logic [31:0] f_addr, l_addr, l_wdata;
   logic        f_gnt, f_rvalid, l_gnt, l_rvalid;
   logic [31:0] f_rdata, l_rdata;
   logic        mem_req, mem_we, timeout;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;

   imem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .f_req(f_req), .f_addr(f_addr), .f_flush(f_flush),
      .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
      .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
      .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .timeout(timeout)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   logic [31:0] f_exp[$];
   logic [31:0] l_exp[$];
   int f_rv_cnt = 0, l_rv_cnt = 0, we_cnt = 0, to_cnt = 0;

   // knobs for the memory model, written only by the main sequence
   int lat = 1;
   bit mute = 1'b0;
   int stray_req = 0;

   function automatic logic [31:0] init_word(input int i);
      logic [7:0] b;
      b = 8'(i);
      return {16'hC0DE, b, b ^ 8'h5A};
   endfunction

   // memory model
   logic [31:0] mem [0:255];
   bit          mem_wr [0:255];
   bit          pend = 1'b0;
   bit          r_we = 1'b0;
   int          wcnt = 0;
   int          stray_ack = 0;
   logic [7:0]  r_idx = '0;

   always @(negedge clk) begin
      if (rst) begin
         pend       <= 1'b0;
         mem_rvalid <= 1'b0;
      end else begin
         mem_rvalid <= 1'b0;
         if (stray_req != stray_ack) begin
            stray_ack  <= stray_ack + 1;
            mem_rvalid <= 1'b1;
            mem_rdata  <= 32'hBAD0_BAD0;
         end else if (pend) begin
            if (wcnt == 0) begin
               mem_rvalid <= 1'b1;
               mem_rdata  <= r_we ? 32'h0 : (mem_wr[r_idx] ? mem[r_idx] : init_word(int'(r_idx)));
               pend       <= 1'b0;
            end else begin
               wcnt <= wcnt - 1;
            end
         end
         if (mem_req && !mute) begin
            pend  <= 1'b1;
            wcnt  <= lat - 1;
            r_idx <= mem_addr[9:2];
            r_we  <= mem_we;
            if (mem_we) begin
               mem[mem_addr[9:2]]    <= mem_wdata;
               mem_wr[mem_addr[9:2]] <= 1'b1;
            end
         end
      end
   end

   // reference contents, updated when a write is driven
   logic [31:0] ref_mem [0:255];
   bit          ref_wr  [0:255];

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_wr[a[9:2]] ? ref_mem[a[9:2]] : init_word(int'(a[9:2]));
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic monitor();
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (f_gnt && l_gnt) chk("gnt_excl", 1, 0);
            if (mem_req && mem_we) we_cnt++;
            if (timeout) to_cnt++;
            if (f_rvalid) begin
               f_rv_cnt++;
               if (f_exp.size() == 0) chk("f_unexp", {32'h0, f_rdata}, 64'hFFFF_FFFF_FFFF_FFFF);
               else chk("f_rdata", f_rdata, f_exp.pop_front());
            end
            if (l_rvalid) begin
               l_rv_cnt++;
               if (l_exp.size() == 0) chk("l_unexp", {32'h0, l_rdata}, 64'hFFFF_FFFF_FFFF_FFFF);
               else chk("l_rdata", l_rdata, l_exp.pop_front());
            end
         end
      end
   endtask

   task automatic do_fetch(input logic [31:0] a, input bit deliver);
      bit got = 1'b0;
      f_addr = a;
      f_req  = 1'b1;
      if (deliver) f_exp.push_back(ref_rd(a));
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (f_gnt) got = 1'b1;
      end
      f_req = 1'b0;
      chk("f_gnt_seen", got, 1);
      if (got) begin
         chk("f_mreq", mem_req, 1);
         chk("f_mwe", mem_we, 0);
         chk("f_maddr", mem_addr, a);
      end
   endtask

   task automatic do_load(input bit we, input logic [31:0] a, input logic [31:0] d);
      bit got = 1'b0;
      l_we    = we;
      l_addr  = a;
      l_wdata = d;
      l_req   = 1'b1;
      l_exp.push_back(we ? 32'h0 : ref_rd(a));
      if (we) begin
         ref_mem[a[9:2]] = d;
         ref_wr[a[9:2]]  = 1'b1;
      end
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (l_gnt) got = 1'b1;
      end
      l_req = 1'b0;
      chk("l_gnt_seen", got, 1);
      if (got) begin
         chk("l_mwe", mem_we, we);
         chk("l_maddr", mem_addr, a);
         chk("l_mwdata", mem_wdata, d);
      end
   endtask

   task automatic drain();
      int n = 0;
      while ((f_exp.size() != 0 || l_exp.size() != 0) && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("drain", f_exp.size() + l_exp.size(), 0);
      repeat (2) @(negedge clk);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ctrl"}, {f_gnt, f_rvalid, l_gnt, l_rvalid, mem_req, mem_we, timeout}, 0);
      chk({tag, "_maddr"}, mem_addr, 0);
      chk({tag, "_mwdata"}, mem_wdata, 0);
      chk({tag, "_frdata"}, f_rdata, 0);
      chk({tag, "_lrdata"}, l_rdata, 0);
   endtask

   initial begin
      int base, k;
      bit seen;
      rst = 1'b1; f_req = 1'b0; f_flush = 1'b0; f_addr = '0;
      l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0;
      for (int i = 0; i < 256; i++) begin
         ref_mem[i] = '0;
         ref_wr[i]  = 1'b0;
      end
      fork monitor(); join_none
      repeat (2) @(negedge clk);
      chk_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // contention from reset: fetch first, then strict alternation
      f_addr = 32'h24; l_addr = 32'h20; l_we = 1'b0; l_wdata = 32'h0;
      f_req = 1'b1; l_req = 1'b1;
      for (int g = 0; g < 4; g++) begin
         seen = 1'b0;
         for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (f_gnt || l_gnt) seen = 1'b1;
         end
         chk("rr_seen", seen, 1);
         chk("rr_order", {f_gnt, l_gnt}, (g % 2 == 0) ? 2'b10 : 2'b01);
         if (f_gnt) f_exp.push_back(ref_rd(32'h24));
         if (l_gnt) l_exp.push_back(ref_rd(32'h20));
      end
      f_req = 1'b0; l_req = 1'b0;
      drain();

      // fetch stream, latency 1: data two cycles after grant
      lat = 1;
      for (int i = 0; i < 3; i++) begin
         do_fetch(32'(i * 4), 1'b1);
         @(negedge clk);
         chk("f_lat_early", f_rvalid, 0);
         @(negedge clk);
         chk("f_lat", f_rvalid, 1);
      end
      drain();

      // loader write then fetch of the written word
      base = we_cnt;
      do_load(1'b1, 32'h10, 32'hDEAD_BEEF);
      drain();
      do_fetch(32'h10, 1'b1);
      drain();
      chk("we_once", we_cnt - base, 1);

      // loader read is unaffected by flush
      do_load(1'b0, 32'h10, 32'h0);
      f_flush = 1'b1;
      @(negedge clk);
      f_flush = 1'b0;
      drain();

      // flush during WAIT drops the response; flush coinciding with rvalid also drops
      lat = 3;
      base = f_rv_cnt;
      do_fetch(32'h30, 1'b0);
      @(negedge clk);
      f_flush = 1'b1;
      @(negedge clk);
      f_flush = 1'b0;
      repeat (6) @(negedge clk);
      chk("flush_drop", f_rv_cnt - base, 0);
      do_fetch(32'h34, 1'b1);
      drain();
      base = f_rv_cnt;
      do_fetch(32'h38, 1'b0);
      repeat (3) @(negedge clk);
      f_flush = 1'b1;
      @(negedge clk);
      f_flush = 1'b0;
      repeat (4) @(negedge clk);
      chk("flush_same", f_rv_cnt - base, 0);

      // timeout, stray response in IDLE, then normal service
      mute = 1'b1;
      base = to_cnt;
      do_fetch(32'h40, 1'b0);
      k = 0;
      seen = 1'b0;
      for (int i = 1; i <= 40 && !seen; i++) begin
         @(negedge clk);
         if (timeout) begin
            seen = 1'b1;
            k = i;
         end
      end
      chk("to_seen", seen, 1);
      chk("to_lat", k, TO);
      @(negedge clk);
      chk("to_pulse", to_cnt - base, 1);
      mute = 1'b0;
      base = f_rv_cnt + l_rv_cnt;
      stray_req = stray_req + 1;
      repeat (4) @(negedge clk);
      chk("stray_ignored", f_rv_cnt + l_rv_cnt - base, 0);
      lat = 2;
      do_fetch(32'h44, 1'b1);
      drain();

      // reset in the middle of WAIT
      lat = 3;
      do_fetch(32'h48, 1'b0);
      @(negedge clk);
      f_req = 1'b1;
      rst = 1'b1;
      #1;
      chk_zero("mid_rst");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      do_fetch(32'h48, 1'b1);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
